// File: rtl/ctrl_encode_def.sv
// Shared encodings for the branch predictor slice.
//   btb_kind_e : entry kind stored in the BTB (conditional branch vs jal/jalr)
//   cnt_wnt/cnt_wt/cnt_max : direction counter initial/allocation/saturation
//                            values as functions of the counter width
package ctrl_encode_def;

  typedef enum logic {
    BTB_KIND_BRANCH = 1'b0,
    BTB_KIND_JUMP   = 1'b1
  } btb_kind_e;

  // Weakly not-taken: just below the taken threshold (MSB clear).
  function automatic int unsigned cnt_wnt(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 32'd1)) - 32'd1;
  endfunction

  // Weakly taken: the smallest value with the MSB set.
  function automatic int unsigned cnt_wt(input int unsigned cnt_w);
    return 32'd1 << (cnt_w - 32'd1);
  endfunction

  function automatic int unsigned cnt_max(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating direction counter next-value logic (combinational).
//   cnt      : current counter value
//   inc/dec  : step towards taken / not-taken, holding at the limits
//   set_max  : force strongly taken (jumps)
//   init     : load weakly taken (fresh allocation)
//   cnt_next : resulting value; priority set_max > init > inc > dec
module sat_counter
  import ctrl_encode_def::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             inc,
  input  logic             dec,
  input  logic             set_max,
  input  logic             init,
  output logic [CNT_W-1:0] cnt_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(cnt_wt(CNT_W));

  always_comb begin
    cnt_next = cnt;
    if (set_max) begin
      cnt_next = CNT_MAX;
    end else if (init) begin
      cnt_next = CNT_WT;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt_next = cnt + 1'b1;
    end else if (dec && (cnt != '0)) begin
      cnt_next = cnt - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters.
//   IF side : if_valid/if_pc in; pred_hit/pred_taken/pred_target out, same cycle
//   ID side : upd_* in at resolution; mispredict/redirect_pc out, same cycle;
//             table trains on the following clock edge
//   inval_all : clears every entry on the next edge (wins over an update)
//   perf_lookups / perf_mispredicts : saturating event counters
module branch_predictor_btb
  import ctrl_encode_def::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned DYNAMIC = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            inval_all,
  output logic [31:0]     perf_lookups,
  output logic [31:0]     perf_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(cnt_wnt(CNT_W));

  // Register array rather than RAM so reset can clear it asynchronously.
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];
  btb_kind_e         kind_q   [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  // Lookup: purely combinational from current table contents.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[XLEN-1:IDX_W+2];

  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = (DYNAMIC != 0) && pred_hit &&
                       ((kind_q[lk_idx] == BTB_KIND_JUMP) || cnt_q[lk_idx][CNT_W-1]);
  assign pred_target = pred_taken ? target_q[lk_idx] : if_pc + XLEN'(4);

  // Resolution side.
  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_write;
  logic [CNT_W-1:0] cnt_nxt;

  assign up_idx   = upd_pc[IDX_W+1:2];
  assign up_tag   = upd_pc[XLEN-1:IDX_W+2];
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  // A miss only allocates when the branch was actually taken.
  assign up_write = upd_valid && (up_hit || upd_taken);

  // On a miss, init selects weakly-taken; jumps override to max either way.
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .cnt      (cnt_q[up_idx]),
    .inc      (up_hit && upd_taken),
    .dec      (up_hit && !upd_taken),
    .set_max  (upd_is_jump),
    .init     (!up_hit),
    .cnt_next (cnt_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        kind_q[i]   <= BTB_KIND_BRANCH;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (inval_all) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_WNT;
      end
    end else if (up_write) begin
      valid_q[up_idx] <= 1'b1;
      cnt_q[up_idx]   <= cnt_nxt;
      if (upd_taken) begin
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        kind_q[up_idx]   <= upd_is_jump ? BTB_KIND_JUMP : BTB_KIND_BRANCH;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lookups     <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (if_valid && (perf_lookups != '1)) begin
        perf_lookups <= perf_lookups + 32'd1;
      end
      if (mispredict && (perf_mispredicts != '1)) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_is_jump = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;
  logic        inval_all = 1'b0;

  logic        pred_hit, pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc, perf_lookups, perf_mispredicts;
  logic        s_hit, s_taken, s_mispredict;
  logic [31:0] s_target, s_redirect, s_lookups, s_mispredicts;

  always #5 clk = ~clk;

  branch_predictor_btb #(
    .XLEN(32), .ENTRIES(16), .CNT_W(2), .DYNAMIC(1)
  ) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .inval_all(inval_all),
    .perf_lookups(perf_lookups), .perf_mispredicts(perf_mispredicts)
  );

  branch_predictor_btb #(
    .XLEN(32), .ENTRIES(16), .CNT_W(2), .DYNAMIC(0)
  ) dut_s (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_hit(s_hit), .pred_taken(s_taken), .pred_target(s_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(s_mispredict), .redirect_pc(s_redirect),
    .inval_all(inval_all),
    .perf_lookups(s_lookups), .perf_mispredicts(s_mispredicts)
  );

  int unsigned total_cnt = 0;
  int unsigned bad_cnt   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic        chk_upd;
    logic        mis;
    logic [31:0] redir;
    logic [31:0] lk;
    logic [31:0] lk_s;
    logic [31:0] mp;
  } exp_t;

  exp_t sb[$];

  // Expected perf counts before the current cycle (saturating).
  logic [31:0] n_look   = '0;
  logic [31:0] n_look_s = '0;
  logic [31:0] n_mis    = '0;

  task automatic step(input logic lv, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc, input logic uj,
                      input logic ut, input logic [31:0] utgt,
                      input logic upt, input logic [31:0] uptgt, input logic inv,
                      input logic eh, input logic et, input logic [31:0] etgt,
                      input logic emis, input logic [31:0] eredir);
    exp_t e;
    @(posedge clk);
    #1;
    if_valid = lv;  if_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_is_jump = uj; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
    inval_all = inv;
    e.pc = lpc; e.hit = eh; e.taken = et; e.tgt = etgt;
    e.chk_upd = uv; e.mis = emis; e.redir = eredir;
    e.lk = n_look; e.lk_s = n_look_s; e.mp = n_mis;
    sb.push_back(e);
    if (lv && n_look != 32'hFFFF_FFFF) n_look = n_look + 32'd1;
    if (lv && n_look_s != 32'hFFFF_FFFF) n_look_s = n_look_s + 32'd1;
    if (emis && n_mis != 32'hFFFF_FFFF) n_mis = n_mis + 32'd1;
  endtask

  task automatic look(input logic [31:0] pc, input logic eh, input logic et,
                      input logic [31:0] etgt);
    step(1'b1, pc, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, eh, et, etgt, 1'b0, '0);
  endtask

  task automatic upd_look(input logic [31:0] lpc, input logic [31:0] upc, input logic uj,
                          input logic ut, input logic [31:0] utgt, input logic upt,
                          input logic [31:0] uptgt, input logic eh, input logic et,
                          input logic [31:0] etgt, input logic emis,
                          input logic [31:0] eredir);
    step(1'b1, lpc, 1'b1, upc, uj, ut, utgt, upt, uptgt, 1'b0, eh, et, etgt, emis, eredir);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pred_hit", {63'd0, pred_hit}, {63'd0, e.hit});
      chk("pred_taken", {63'd0, pred_taken}, {63'd0, e.taken});
      chk("pred_target", {32'd0, pred_target}, {32'd0, e.tgt});
      chk("mispredict", {63'd0, mispredict}, {63'd0, e.mis});
      if (e.chk_upd) chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, e.redir});
      chk("perf_lookups", {32'd0, perf_lookups}, {32'd0, e.lk});
      chk("perf_mispredicts", {32'd0, perf_mispredicts}, {32'd0, e.mp});
      chk("static_hit", {63'd0, s_hit}, {63'd0, e.hit});
      chk("static_taken", {63'd0, s_taken}, 64'd0);
      chk("static_target", {32'd0, s_target}, {32'd0, e.pc + 32'd4});
      chk("static_mispredict", {63'd0, s_mispredict}, {63'd0, e.mis});
      chk("static_lookups", {32'd0, s_lookups}, {32'd0, e.lk_s});
      chk("static_mispredicts", {32'd0, s_mispredicts}, {32'd0, e.mp});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    look(32'h100, 0, 0, 32'h104);
    // allocate branch at 0x100 (weakly taken)
    upd_look(32'h100, 32'h100, 0, 1, 32'h80, 0, 32'h104, 0, 0, 32'h104, 1, 32'h80);
    look(32'h100, 1, 1, 32'h80);
    // train not-taken: 2->1, then 1->0, then hold at 0
    upd_look(32'h100, 32'h100, 0, 0, 32'h0, 1, 32'h80, 1, 1, 32'h80, 1, 32'h104);
    upd_look(32'h100, 32'h100, 0, 0, 32'h0, 0, 32'h104, 1, 0, 32'h104, 0, 32'h104);
    upd_look(32'h100, 32'h100, 0, 0, 32'h0, 0, 32'h104, 1, 0, 32'h104, 0, 32'h104);
    // taken once from 0 -> 1, still not taken
    upd_look(32'h100, 32'h100, 0, 1, 32'h80, 0, 32'h104, 1, 0, 32'h104, 1, 32'h80);
    look(32'h100, 1, 0, 32'h104);
    // alias at the same index evicts 0x100
    upd_look(32'h140, 32'h140, 0, 1, 32'h40, 0, 32'h144, 0, 0, 32'h144, 1, 32'h40);
    look(32'h100, 0, 0, 32'h104);
    look(32'h140, 1, 1, 32'h40);
    // jal at 0x200 predicted taken straight after allocation
    upd_look(32'h200, 32'h200, 1, 1, 32'h400, 0, 32'h204, 0, 0, 32'h204, 1, 32'h400);
    look(32'h200, 1, 1, 32'h400);
    upd_look(32'h140, 32'h200, 1, 1, 32'h400, 1, 32'h400, 0, 0, 32'h144, 0, 32'h400);
    // correct direction, wrong target -> mispredict and retarget
    upd_look(32'h200, 32'h200, 1, 1, 32'h500, 1, 32'h400, 1, 1, 32'h400, 1, 32'h500);
    // if_valid low: outputs still reflect the table, no lookup counted
    step(0, 32'h200, 0, '0, 0, 0, '0, 0, '0, 0, 1, 1, 32'h500, 0, '0);
    upd_look(32'h104, 32'h104, 0, 1, 32'h10, 0, 32'h108, 0, 0, 32'h108, 1, 32'h10);
    look(32'h104, 1, 1, 32'h10);
    // inval_all with a simultaneous allocating update: update dropped
    step(1, 32'h104, 1, 32'h300, 0, 1, 32'h20, 0, 32'h304, 1, 1, 1, 32'h10, 1, 32'h20);
    look(32'h300, 0, 0, 32'h304);
    look(32'h104, 0, 0, 32'h108);
    look(32'h200, 0, 0, 32'h204);
    // not-taken miss does not allocate
    upd_look(32'h180, 32'h180, 0, 0, 32'h0, 0, 32'h184, 0, 0, 32'h184, 0, 32'h184);
    look(32'h180, 0, 0, 32'h184);
    // allocate a jump at 0x300 with no lookup counted, then idle
    step(0, 32'h300, 1, 32'h300, 1, 1, 32'h30, 0, 32'h304, 0, 0, 0, 32'h304, 1, 32'h30);
    step(0, 32'h300, 0, '0, 0, 0, '0, 0, '0, 0, 1, 1, 32'h30, 0, '0);

    // asynchronous reset mid-stream
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_lookups", {32'd0, perf_lookups}, 64'd0);
    chk("rst_mispredicts", {32'd0, perf_mispredicts}, 64'd0);
    chk("rst_hit", {63'd0, pred_hit}, 64'd0);
    chk("rst_taken", {63'd0, pred_taken}, 64'd0);
    chk("rst_target", {32'd0, pred_target}, 64'h304);
    @(posedge clk);
    #1 reset = 1'b0;
    n_look = '0; n_look_s = '0; n_mis = '0;

    look(32'h300, 0, 0, 32'h304);
    step(0, 32'h300, 0, '0, 0, 0, '0, 0, '0, 0, 0, 0, 32'h304, 0, '0);

    // preload the lookup counter near its limit, then count into saturation
    @(negedge clk);
    #1 force dut.perf_lookups = 32'hFFFF_FFFD;
    @(posedge clk);
    #1 release dut.perf_lookups;
    n_look = 32'hFFFF_FFFD;
    repeat (4) look(32'h300, 0, 0, 32'h304);
    step(0, 32'h300, 0, '0, 0, 0, '0, 0, '0, 0, 0, 0, 32'h304, 0, '0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) chk("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
Parametrised branch target buffer plus per-entry saturating-counter direction predictor for the 5-stage pipeline.
- IF side: predicts next PC in the same cycle as fetch, replacing the fixed PC+4 and the flush-on-taken policy.
- ID side: trained at branch/jump resolution; flags mispredicts and supplies the redirect PC.
- Keeps a lookup counter and a mispredict counter.

Parameters:
XLEN, 32, address/data width
ENTRIES, 16, BTB entries; power of two, >=2; IDX_W = log2(ENTRIES)
CNT_W, 2, direction counter width; >=1
DYNAMIC, 1, 1 = use table prediction; 0 = static not-taken (table still trains)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
if_valid  in  1  fetch slot valid this cycle (low while stalled)
if_pc  in  XLEN  fetch PC
pred_hit  out  1  valid entry with matching tag for if_pc
pred_taken  out  1  predicted taken
pred_target  out  XLEN  predicted next PC
upd_valid  in  1  a branch/jump resolved in ID this cycle
upd_pc  in  XLEN  PC of resolved instruction
upd_is_jump  in  1  1 = jal/jalr, 0 = conditional branch
upd_taken  in  1  actual outcome
upd_target  in  XLEN  actual target when taken
upd_pred_taken  in  1  prediction that travelled with the instruction
upd_pred_target  in  XLEN  predicted target that travelled with it
mispredict  out  1  redirect/flush required
redirect_pc  out  XLEN  correct next PC when mispredict
inval_all  in  1  invalidate whole table (fence.i / context change)
perf_lookups  out  32  count of if_valid cycles, saturating
perf_mispredicts  out  32  count of mispredict cycles, saturating

Behaviour:
- Index: pc[IDX_W+1:2]. Tag: pc[XLEN-1:IDX_W+2].
- Entry fields: valid, tag, target, kind (branch/jump), cnt[CNT_W-1:0].
- Reset (async): all valid=0; all cnt=WNT (2^(CNT_W-1)-1); perf counters=0.
- Lookup is combinational from current table state, zero latency.
  - pred_hit = valid & tag match.
  - pred_taken = DYNAMIC & pred_hit & (kind==jump | cnt[CNT_W-1]).
  - pred_target = pred_taken ? entry.target : if_pc+4.
  - All three outputs are held to their values even when if_valid=0; no state change.
- mispredict (combinational) = upd_valid & (upd_taken!=upd_pred_taken | (upd_taken & upd_target!=upd_pred_target)).
- redirect_pc = upd_taken ? upd_target : upd_pc+4.
- Table update is registered on the clk edge after the upd_valid cycle.
  - Hit, branch: cnt saturating +1 if taken, -1 if not; at max/0 it holds.
  - Hit, taken: target<=upd_target. kind<=upd_is_jump.
  - Hit, jump: cnt<=max.
  - Miss, taken: allocate (direct-mapped overwrite). valid=1, tag, target; kind=upd_is_jump; cnt = jump ? max : WT (2^(CNT_W-1)).
  - Miss, not taken: no allocation, no change.
- Simultaneous lookup and update to the same index: lookup sees the pre-update contents; no bypass.
- inval_all: all valid<=0 and cnt<=WNT on the next edge. It takes priority over an update in the same cycle; the update is dropped.
- Perf counters: perf_lookups += if_valid; perf_mispredicts += mispredict. Both saturate at 32'hFFFFFFFF.
- Reset asserted mid-operation: immediate clear per reset values; outputs reflect the empty table (pred_taken=0, pred_target=if_pc+4).
- CNT_W=1: counter is 1-bit last-outcome; WNT=0, WT=1.

Decomposition:
- Shared package (ctrl_encode_def): BTB_KIND_BRANCH/BTB_KIND_JUMP encodings and the counter-init formulas WNT/WT/MAX as macros/functions of CNT_W.
- One sub-module: sat_counter (CNT_W parameter; inc/dec/set-max/init inputs; saturating next value).
- The table is a register array, not a RAM macro, because reset must clear it asynchronously.

Test Plan:
- Reset, then lookup if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104, perf counters 0.
- Update pc=0x100 branch taken, target 0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle lookup 0x100 -> hit, taken, target 0x80 (cnt=2).
- Train 0x100 not-taken twice -> cnt 2->1->0, lookup not taken, target 0x104. A third not-taken holds cnt at 0. Then taken once -> cnt=1, still not taken.
- Alias: pc=0x140 taken (ENTRIES=16, same index as 0x100) evicts 0x100 -> lookup 0x100 misses, 0x140 hits. jal at 0x200 -> predicted taken immediately (cnt=max).
- inval_all and upd_valid (taken, pc=0x300) in the same cycle -> all lookups miss afterwards, including 0x300. Reset pulse mid-stream -> perf counters 0 asynchronously.
- DYNAMIC=0, trained entry -> pred_taken=0 while pred_hit=1. Force 2^32 lookups (preload) -> perf_lookups saturates at 0xFFFFFFFF.
